// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: keypad-driven sequencer for an 8-bit ALU and an 8-digit display.
// Collects operand X, then operand Y, from hex key strobes. ENTER in ST_Y (or
// ST_SHOW) latches opcode/carry and launches the ALU. After a fixed latency the
// controller captures the 16-bit result and shows {X, Y, result}.
//
// Handshake: there is no valid/ready pair on this block. key_stb is a one-cycle
// qualifier for key_code. alu_go is a one-cycle launch pulse; the ALU is trusted
// to present a valid alu_ans ALU_LAT cycles after it. done is a one-cycle pulse
// in the cycle after alu_ans is captured into result.
module alu_seq_ctrl #(
  parameter int ALU_LAT = 2,
  parameter int DIGITS  = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        key_stb,
  input  logic [4:0]  key_code,
  input  logic [2:0]  op_sw,
  input  logic        cin_sw,
  input  logic [15:0] alu_ans,
  output logic [7:0]  X,
  output logic [7:0]  Y,
  output logic [2:0]  S,
  output logic        cin,
  output logic        alu_go,
  output logic [15:0] result,
  output logic [31:0] N,
  output logic        disp_clr,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_X    = 3'd0,
    ST_Y    = 3'd1,
    ST_EXEC = 3'd2,
    ST_SHOW = 3'd3
  } state_t;

  localparam logic [4:0] KEY_ENTER = 5'd16;
  localparam logic [4:0] KEY_CLEAR = 5'd17;
  localparam logic [4:0] KEY_BS    = 5'd18;

  localparam int            CW      = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [3:0]    LAT     = 4'(ALU_LAT);

  state_t          state_q,  state_d;
  logic [7:0]      x_q,      x_d;
  logic [7:0]      y_q,      y_d;
  logic [2:0]      s_q,      s_d;
  logic            cin_q,    cin_d;
  logic [15:0]     result_q, result_d;
  logic [CW-1:0]   cnt_x_q,  cnt_x_d;
  logic [CW-1:0]   cnt_y_q,  cnt_y_d;
  logic [3:0]      wait_q,   wait_d;
  logic            alu_go_q, alu_go_d;
  logic            done_q,   done_d;

  // Key decode: only strobed cycles act, codes 19..31 decode to nothing.
  logic key_digit, key_enter, key_clear, key_bs;
  assign key_digit = key_stb && (key_code[4] == 1'b0);
  assign key_enter = key_stb && (key_code == KEY_ENTER);
  assign key_clear = key_stb && (key_code == KEY_CLEAR);
  assign key_bs    = key_stb && (key_code == KEY_BS);

  // Next-state and register-update logic; every register holds by default.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    s_d      = s_q;
    cin_d    = cin_q;
    result_d = result_q;
    cnt_x_d  = cnt_x_q;
    cnt_y_d  = cnt_y_q;
    wait_d   = wait_q;
    alu_go_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_X: begin
        if (key_digit) begin
          x_d     = {x_q[3:0], key_code[3:0]};
          cnt_x_d = (cnt_x_q == CNT_MAX) ? cnt_x_q : cnt_x_q + CNT_ONE;
        end else if (key_bs) begin
          if (cnt_x_q != '0) begin
            x_d     = {4'h0, x_q[7:4]};
            cnt_x_d = cnt_x_q - CNT_ONE;
          end
        end else if (key_enter) begin
          state_d = ST_Y;
          y_d     = 8'h00;
          cnt_y_d = '0;
        end
      end

      ST_Y: begin
        if (key_digit) begin
          y_d     = {y_q[3:0], key_code[3:0]};
          cnt_y_d = (cnt_y_q == CNT_MAX) ? cnt_y_q : cnt_y_q + CNT_ONE;
        end else if (key_bs) begin
          if (cnt_y_q != '0) begin
            y_d     = {4'h0, y_q[7:4]};
            cnt_y_d = cnt_y_q - CNT_ONE;
          end
        end else if (key_enter) begin
          state_d  = ST_EXEC;
          s_d      = op_sw;
          cin_d    = cin_sw;
          alu_go_d = 1'b1;
          wait_d   = LAT;
        end
      end

      // Keys (CLEAR included) are deliberately dropped while the ALU runs so
      // its inputs never change mid-operation.
      ST_EXEC: begin
        if (wait_q == 4'd0) begin
          state_d  = ST_SHOW;
          result_d = alu_ans;
          done_d   = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_SHOW: begin
        if (key_digit) begin
          state_d  = ST_X;
          x_d      = {4'h0, key_code[3:0]};
          cnt_x_d  = CNT_ONE;
          y_d      = 8'h00;
          cnt_y_d  = '0;
          result_d = 16'h0000;
        end else if (key_enter) begin
          state_d  = ST_EXEC;
          s_d      = op_sw;
          cin_d    = cin_sw;
          alu_go_d = 1'b1;
          wait_d   = LAT;
        end
      end

      default: begin
        state_d = ST_X;
      end
    endcase

    // CLEAR acts like reset everywhere except ST_EXEC.
    if (key_clear && (state_q != ST_EXEC)) begin
      state_d  = ST_X;
      x_d      = 8'h00;
      y_d      = 8'h00;
      s_d      = 3'b000;
      cin_d    = 1'b0;
      result_d = 16'h0000;
      cnt_x_d  = '0;
      cnt_y_d  = '0;
      wait_d   = 4'd0;
      alu_go_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= ST_X;
      x_q      <= 8'h00;
      y_q      <= 8'h00;
      s_q      <= 3'b000;
      cin_q    <= 1'b0;
      result_q <= 16'h0000;
      cnt_x_q  <= '0;
      cnt_y_q  <= '0;
      wait_q   <= 4'd0;
      alu_go_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      s_q      <= s_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      cnt_x_q  <= cnt_x_d;
      cnt_y_q  <= cnt_y_d;
      wait_q   <= wait_d;
      alu_go_q <= alu_go_d;
      done_q   <= done_d;
    end
  end

  assign X        = x_q;
  assign Y        = y_q;
  assign S        = s_q;
  assign cin      = cin_q;
  assign alu_go   = alu_go_q;
  assign result   = result_q;
  assign done     = done_q;
  assign state    = state_q;
  assign N        = {x_q, y_q, result_q};
  assign busy     = (state_q == ST_EXEC);
  assign disp_clr = (state_q == ST_X) && (cnt_x_q == '0) && (result_q == 16'h0000);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl with a behavioural ALU (ALU_LAT = 2).
module tb_alu_seq_ctrl;

  logic        clk;
  logic        clr_n;
  logic        key_stb;
  logic [4:0]  key_code;
  logic [2:0]  op_sw;
  logic        cin_sw;
  logic [15:0] alu_ans;
  logic [7:0]  X, Y;
  logic [2:0]  S;
  logic        cin, alu_go, disp_clr, busy, done;
  logic [15:0] result;
  logic [31:0] N;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;
  int go_cnt = 0;
  int done_cnt = 0;

  alu_seq_ctrl #(.ALU_LAT(2), .DIGITS(2)) dut (
    .clk(clk), .clr_n(clr_n), .key_stb(key_stb), .key_code(key_code),
    .op_sw(op_sw), .cin_sw(cin_sw), .alu_ans(alu_ans),
    .X(X), .Y(Y), .S(S), .cin(cin), .alu_go(alu_go), .result(result),
    .N(N), .disp_clr(disp_clr), .busy(busy), .done(done), .state(state)
  );

  // Clock and pulse counters
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (alu_go) go_cnt++;
    if (done)   done_cnt++;
  end

  // Behavioural ALU: 001 = add with carry, 010 = multiply, else xor.
  always_comb begin
    case (S)
      3'b001:  alu_ans = {8'h00, X} + {8'h00, Y} + {15'h0000, cin};
      3'b010:  alu_ans = {8'h00, X} * {8'h00, Y};
      default: alu_ans = {8'h00, X ^ Y};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; strobes one key for exactly one rising edge.
  task automatic press(input logic [4:0] code);
    key_stb  = 1'b1;
    key_code = code;
    @(negedge clk);
    key_stb  = 1'b0;
    key_code = 5'd0;
  endtask

  // Waits (bounded) for done; returns cycles waited and cycles busy was low.
  task automatic wait_done(output int cyc, output int busy_lo);
    cyc = 0;
    busy_lo = 0;
    while (!done && cyc < 20) begin
      if (!busy) busy_lo++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_N"}, N, 32'h0);
    chk({tag, "_S_cin"}, {28'h0, S, cin}, 32'h0);
    chk({tag, "_flags"}, {27'h0, alu_go, done, busy, disp_clr, 1'b0}, 32'h2);
  endtask

  int cyc, blo, g0, d0;

  initial begin
    clr_n = 1'b0; key_stb = 1'b0; key_code = 5'd0; op_sw = 3'b000; cin_sw = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    chk_reset_vals("reset");

    // X=12, Y=34, add
    press(5'd1); press(5'd2);
    chk("x_12", 32'(X), 32'h12);
    chk("disp_clr_digit", 32'(disp_clr), 32'd0);
    press(5'd16);
    chk("enter_x_state", 32'(state), 32'd1);
    press(5'd3); press(5'd4);
    chk("y_34", 32'(Y), 32'h34);
    op_sw = 3'b001; cin_sw = 1'b0;
    g0 = go_cnt;
    press(5'd16);
    chk("exec_state", 32'(state), 32'd2);
    chk("exec_go", 32'(alu_go), 32'd1);
    chk("exec_S", 32'(S), 32'd1);
    wait_done(cyc, blo);
    chk("add_latency", 32'(cyc), 32'd3);
    chk("add_busy_lo", 32'(blo), 32'd0);
    chk("add_result", 32'(result), 32'h0046);
    chk("add_N", N, 32'h1234_0046);
    chk("add_show", 32'(state), 32'd3);
    chk("add_go_once", 32'(go_cnt - g0), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    // Re-execute from SHOW with carry in
    cin_sw = 1'b1;
    press(5'd16);
    wait_done(cyc, blo);
    chk("addc_result", 32'(result), 32'h0047);
    chk("addc_cin", 32'(cin), 32'd1);

    // Re-execute with multiply; keys during EXEC ignored
    op_sw = 3'b010; cin_sw = 1'b0;
    g0 = go_cnt;
    press(5'd16);
    chk("mul_go", 32'(alu_go), 32'd1);
    chk("mul_S", 32'(S), 32'd2);
    press(5'd17);
    press(5'd5);
    chk("exec_ign_state", 32'(state), 32'd2);
    chk("exec_ign_busy", 32'(busy), 32'd1);
    chk("exec_ign_XY", {16'h0, X, Y}, 32'h1234);
    wait_done(cyc, blo);
    chk("mul_latency", 32'(cyc), 32'd1);
    chk("mul_N", N, 32'h1234_03A8);
    chk("mul_go_once", 32'(go_cnt - g0), 32'd1);

    // Digit from SHOW starts a new entry
    press(5'd7);
    chk("new_state", 32'(state), 32'd0);
    chk("new_N", N, 32'h0700_0000);
    chk("new_disp_clr", 32'(disp_clr), 32'd0);

    // Shifting and backspace
    press(5'd10); press(5'd11); press(5'd12);
    chk("x_BC", 32'(X), 32'hBC);
    press(5'd18);
    chk("bs_0B", 32'(X), 32'h0B);
    press(5'd18); press(5'd18);
    chk("bs_00", 32'(X), 32'h00);
    chk("bs_disp_clr", 32'(disp_clr), 32'd1);
    press(5'd18);
    chk("bs_extra_state", 32'(state), 32'd0);
    chk("bs_extra_X", 32'(X), 32'h00);

    // Abort mid-EXEC with reset
    op_sw = 3'b001;
    press(5'd1); press(5'd16); press(5'd2);
    press(5'd16);
    chk("abort_exec", 32'(state), 32'd2);
    d0 = done_cnt;
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    chk_reset_vals("abort");
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Key during reset is dropped
    clr_n = 1'b0;
    press(5'd9);
    clr_n = 1'b1;
    chk("rst_key_X", 32'(X), 32'h00);
    chk("rst_key_disp", 32'(disp_clr), 32'd1);

    // CLEAR in ST_Y, then unknown code
    press(5'd5); press(5'd10); press(5'd16);
    chk("y_entry_X", 32'(X), 32'h5A);
    press(5'd3);
    press(5'd17);
    chk_reset_vals("clear_y");
    press(5'd20);
    chk_reset_vals("unknown");
    press(5'd6); press(5'd20);
    chk("unknown_X", 32'(X), 32'h06);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
